// File: rtl/periph_arb_pkg.sv
// Shared types and constants for the peripheral register-bank arbiter.
package periph_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic REQ_I2C   = 1'b0;
  localparam logic REQ_LOCAL = 1'b1;

  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_LOCK_MAX = 4;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a tie goes to the port that did not win last,
// unless force_tie hands it back to last_winner (used to break a lock run).
module rr_pick2
  import periph_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_winner,
  input  logic       force_tie,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    winner = REQ_I2C;
    case (req)
      2'b10:   winner = REQ_LOCAL;
      2'b11:   winner = force_tie ? last_winner : ~last_winner;
      default: winner = REQ_I2C;
    endcase
  end

  assign valid = |req;

endmodule

// File: rtl/periph_reg_arbiter.sv
// Round-robin arbiter sharing the peripheral register bank between the I2C
// slave and local logic. Optional grant locking is enabled by `define ARB_LOCK_EN.
module periph_reg_arbiter
  import periph_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_i,
  input  logic [1:0]            we_i,
  input  logic [2*ADDR_W-1:0]   addr_i,
  input  logic [2*DATA_W-1:0]   wdata_i,
  input  logic [1:0]            lock_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  bus_en_o,
  output logic                  bus_we_o,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [DATA_W-1:0]     bus_wdata_o,
  input  logic [DATA_W-1:0]     bus_rdata_i
);

  state_t            state;
  logic              sel;
  logic              last_winner;
  logic              pick;
  logic              pick_valid;
  logic              force_tie;
  logic              next_lw;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign win_addr  = (pick == REQ_LOCAL) ? addr_i[ADDR_W +: ADDR_W]  : addr_i[0 +: ADDR_W];
  assign win_wdata = (pick == REQ_LOCAL) ? wdata_i[DATA_W +: DATA_W] : wdata_i[0 +: DATA_W];

  rr_pick2 u_pick (
    .req         (req_i),
    .last_winner (last_winner),
    .force_tie   (force_tie),
    .winner      (pick),
    .valid       (pick_valid)
  );

`ifdef ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             is_other;

  // A locked grant keeps last_winner pointing away from the owner so the owner
  // wins the next tie; once the run is full the next tie is handed over.
  assign force_tie = (lock_cnt == CNT_W'(LOCK_MAX));

  always_comb begin
    is_other = (lock_cnt != '0) && (pick == last_winner);
    next_lw  = pick;
    next_cnt = '0;
    if (lock_i[pick]) begin
      if (is_other || lock_cnt == '0) begin
        next_lw  = ~pick;
        next_cnt = CNT_W'(1);
      end else if (lock_cnt != CNT_W'(LOCK_MAX)) begin
        next_lw  = ~pick;
        next_cnt = lock_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
    end else if (state == ST_IDLE && pick_valid) begin
      lock_cnt <= next_cnt;
    end
  end
`else
  localparam int UNUSED_LOCK_MAX = LOCK_MAX;
  logic unused_lock;

  assign unused_lock = ^lock_i;
  assign force_tie   = 1'b0;
  assign next_lw     = pick;
`endif

  // Read data is only valid from the bank during RESP, so it is passed through
  // there and held afterwards until the next response.
  assign rdata_o = (state == ST_RESP) ? (bus_we_o ? '0 : bus_rdata_i) : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sel         <= REQ_I2C;
      last_winner <= REQ_LOCAL;
      gnt_o       <= '0;
      rvalid_o    <= '0;
      rdata_q     <= '0;
      bus_en_o    <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            sel         <= pick;
            last_winner <= next_lw;
            bus_en_o    <= 1'b1;
            bus_we_o    <= we_i[pick];
            bus_addr_o  <= win_addr;
            bus_wdata_o <= win_wdata;
            gnt_o       <= (pick == REQ_LOCAL) ? 2'b10 : 2'b01;
            state       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          bus_en_o <= 1'b0;
          gnt_o    <= '0;
          rvalid_o <= (sel == REQ_LOCAL) ? 2'b10 : 2'b01;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          rvalid_o <= '0;
          rdata_q  <= rdata_o;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_reg_arbiter.sv
// Randomised scoreboard bench for periph_reg_arbiter with a cycle-level
// reference model of the arbitration rules and a behavioural register bank.
module tb_periph_reg_arbiter;

  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 8;
  localparam int LOCK_MAX = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [1:0]          req_i = '0;
  logic [1:0]          we_i = '0;
  logic [1:0]          lock_i = '0;
  logic [2*ADDR_W-1:0] addr_i = '0;
  logic [2*DATA_W-1:0] wdata_i = '0;
  logic [1:0]          gnt_o;
  logic [1:0]          rvalid_o;
  logic [DATA_W-1:0]   rdata_o;
  logic                bus_en_o;
  logic                bus_we_o;
  logic [ADDR_W-1:0]   bus_addr_o;
  logic [DATA_W-1:0]   bus_wdata_o;
  logic [DATA_W-1:0]   bus_rdata_i = '0;

  always #5 clk = ~clk;

  periph_reg_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .lock_i      (lock_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .bus_en_o    (bus_en_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata_i)
  );

  // Register bank: synchronous write, registered read.
  logic [DATA_W-1:0] bank [8] = '{default: '0};

  always @(posedge clk) begin
    if (bus_en_o) begin
      if (bus_we_o) bank[bus_addr_o] <= bus_wdata_o;
      else          bus_rdata_i <= bank[bus_addr_o];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit       we;
    bit [2:0] addr;
    bit [7:0] wdata;
    bit       lock;
    int       gap;
    int       withdraw;
  } tx_t;

  tx_t txbuf [2][256];
  int  tail [2] = '{0, 0};
  int  head [2] = '{0, 0};
  bit  active [2] = '{0, 0};
  int  age [2] = '{0, 0};
  int  gapc [2] = '{0, 0};
  bit  gap_loaded [2] = '{0, 0};
  int  cur_wd [2] = '{0, 0};

  task automatic applyStimulus(input int p, input bit we, input bit [2:0] addr, input bit [7:0] wdata,
                               input bit lock, input int gap, input int withdraw);
    txbuf[p][tail[p]] = '{we, addr, wdata, lock, gap, withdraw};
    tail[p]++;
  endtask

  // Requester driver: holds a request until granted or deliberately withdrawn.
  always @(negedge clk) begin
    if (!rst_n) begin
      req_i  = '0;
      lock_i = '0;
      for (int p = 0; p < 2; p++) begin
        active[p]     = 1'b0;
        gap_loaded[p] = 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (active[p]) begin
          if (gnt_o[p] || (cur_wd[p] != 0 && age[p] >= cur_wd[p])) begin
            req_i[p]  = 1'b0;
            lock_i[p] = 1'b0;
            active[p] = 1'b0;
          end else begin
            age[p]++;
          end
        end else if (head[p] < tail[p]) begin
          if (!gap_loaded[p]) begin
            gapc[p]       = txbuf[p][head[p]].gap;
            gap_loaded[p] = 1'b1;
          end
          if (gapc[p] > 0) begin
            gapc[p]--;
          end else begin
            we_i[p]             = txbuf[p][head[p]].we;
            addr_i[p*3 +: 3]    = txbuf[p][head[p]].addr;
            wdata_i[p*8 +: 8]   = txbuf[p][head[p]].wdata;
            lock_i[p]           = txbuf[p][head[p]].lock;
            cur_wd[p]           = txbuf[p][head[p]].withdraw;
            req_i[p]            = 1'b1;
            active[p]           = 1'b1;
            age[p]              = 0;
            gap_loaded[p]       = 1'b0;
            head[p]++;
          end
        end
      end
    end
  end

  typedef struct {
    int       port;
    bit       we;
    bit [2:0] addr;
    bit [7:0] wdata;
    bit [7:0] data;
    int       gcyc;
  } exp_t;

  exp_t     sbq [$];
  exp_t     em;
  bit [7:0] mem_m [8] = '{default: 8'h00};
  int       mbusy = 0;
  bit       mlast = 1'b1;
  int       run = 0;
  bit       owner = 1'b0;
  int       w;

  // Reference model: an access occupies the sampling cycle plus two more; the
  // arbitration outcome is pushed as an expected grant/response pair.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbusy = 0;
      mlast = 1'b1;
      run   = 0;
      owner = 1'b0;
      sbq.delete();
    end else begin
      if (mbusy == 2) begin
        em = sbq.pop_back();
        em.data = em.we ? 8'h00 : mem_m[em.addr];
        if (em.we) mem_m[em.addr] = em.wdata;
        sbq.push_back(em);
        mbusy = 1;
      end else if (mbusy == 1) begin
        mbusy = 0;
      end else if (req_i != 2'b00) begin
        if (req_i == 2'b01) w = 0;
        else if (req_i == 2'b10) w = 1;
        else begin
`ifdef ARB_LOCK_EN
          if (run == 0) w = mlast ? 0 : 1;
          else if (run < LOCK_MAX) w = owner ? 1 : 0;
          else w = owner ? 0 : 1;
`else
          w = mlast ? 0 : 1;
`endif
        end
        em.port  = w;
        em.we    = we_i[w];
        em.addr  = addr_i[w*3 +: 3];
        em.wdata = wdata_i[w*8 +: 8];
        em.data  = 8'h00;
        em.gcyc  = cyc + 1;
        sbq.push_back(em);
        mlast = (w == 1);
`ifdef ARB_LOCK_EN
        if (!lock_i[w]) run = 0;
        else if (run > 0 && (w == 1) == owner) begin
          if (run == LOCK_MAX) run = 0;
          else run++;
        end else begin
          owner = (w == 1);
          run   = 1;
        end
`endif
        mbusy = 2;
      end
      cyc++;
    end
  end

  exp_t     ek;
  bit [7:0] held = 8'h00;
  bit [1:0] exp_g;
  bit [1:0] exp_v;

  // Monitor: compares every cycle's handshake outputs against the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 8'h00;
    end else begin
      exp_g = 2'b00;
      exp_v = 2'b00;
      if (sbq.size() > 0) begin
        ek = sbq[0];
        if (ek.gcyc == cyc)     exp_g = (ek.port == 1) ? 2'b10 : 2'b01;
        if (ek.gcyc + 1 == cyc) exp_v = (ek.port == 1) ? 2'b10 : 2'b01;
      end
      checkOutput("gnt_o", 32'(gnt_o), 32'(exp_g));
      checkOutput("rvalid_o", 32'(rvalid_o), 32'(exp_v));
      checkOutput("bus_en_o", 32'(bus_en_o), 32'(exp_g != 2'b00));
      if (exp_g != 2'b00) begin
        checkOutput("bus_we_o", 32'(bus_we_o), 32'(ek.we));
        checkOutput("bus_addr_o", 32'(bus_addr_o), 32'(ek.addr));
        checkOutput("bus_wdata_o", 32'(bus_wdata_o), 32'(ek.wdata));
      end
      if (exp_v != 2'b00) begin
        checkOutput("rdata_o", 32'(rdata_o), 32'(ek.data));
        held = ek.data;
        void'(sbq.pop_front());
      end else begin
        checkOutput("rdata_hold", 32'(rdata_o), 32'(held));
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_gnt"}, 32'(gnt_o), 32'h0);
    checkOutput({tag, "_rvalid"}, 32'(rvalid_o), 32'h0);
    checkOutput({tag, "_rdata"}, 32'(rdata_o), 32'h0);
    checkOutput({tag, "_bus_en"}, 32'(bus_en_o), 32'h0);
    checkOutput({tag, "_bus_we"}, 32'(bus_we_o), 32'h0);
    checkOutput({tag, "_bus_addr"}, 32'(bus_addr_o), 32'h0);
    checkOutput({tag, "_bus_wdata"}, 32'(bus_wdata_o), 32'h0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic waitDrain(input int limit);
    int n;
    n = 0;
    while (n < limit && !(head[0] == tail[0] && head[1] == tail[1] && !active[0] && !active[1]
                          && sbq.size() == 0)) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) checkOutput("drain_timeout", 32'(n), 32'(limit - 1));
  endtask

  initial begin
    int n;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    #1 checkResetOutputs("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Reset in the middle of a write: outputs clear at once, bank untouched.
    applyStimulus(0, 1'b1, 3'd2, 8'h77, 1'b0, 0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt_o[0] && n < 20);
    if (!gnt_o[0]) checkOutput("midreset_gnt_wait", 32'(gnt_o), 32'h1);
    #1 rst_n = 1'b0;
    #1 checkResetOutputs("midreset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(0, 1'b0, 3'd2, 8'h00, 1'b0, 1, 0);
    waitDrain(100);

    // Single write then read-back from port 0.
    applyStimulus(0, 1'b1, 3'd3, 8'hA5, 1'b0, 0, 0);
    applyStimulus(0, 1'b0, 3'd3, 8'h00, 1'b0, 0, 0);
    waitDrain(100);

    // Simultaneous requests straight after reset, then continuous contention.
    applyReset();
    applyStimulus(0, 1'b0, 3'd1, 8'h00, 1'b0, 0, 0);
    applyStimulus(1, 1'b1, 3'd1, 8'h3C, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1'b0, 3'(i), 8'(i), 1'b0, 0, 0);
      applyStimulus(1, 1'b1, 3'(i + 4), 8'(8'h40 + i), 1'b0, 0, 0);
    end
    waitDrain(200);

    // Port 1 streams four reads alone.
    for (int i = 4; i < 8; i++) applyStimulus(1, 1'b0, 3'(i), 8'h00, 1'b0, 0, 0);
    waitDrain(200);

    // Port 1 withdraws while port 0's access is still on the bus.
    applyStimulus(0, 1'b1, 3'd6, 8'h99, 1'b0, 0, 0);
    applyStimulus(1, 1'b1, 3'd6, 8'h11, 1'b0, 1, 1);
    waitDrain(100);

    // Both contend while port 0 asks for locked grants.
    applyReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1'b1, 3'd0, 8'(8'h80 + i), 1'b1, 0, 0);
      applyStimulus(1, 1'b0, 3'd0, 8'h00, 1'b0, 0, 0);
    end
    waitDrain(300);

    for (int i = 0; i < 100; i++) begin
      for (int p = 0; p < 2; p++) begin
        applyStimulus(p, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
    end
    waitDrain(5000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
